// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, opcode-class types and RV32I opcode constants for the multi-cycle control FSM
package multicycle_ctrl_pkg;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} ctrl_state_t;
  typedef enum logic [2:0] {CL_NONE, CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH} op_class_t;
  function automatic op_class_t op_class(input logic [6:0] op);
    return op == R_TYPE ? CL_R :
           op == I_TYPE ? CL_I :
           op == LOAD   ? CL_LOAD :
           op == STORE  ? CL_STORE :
           op == BRANCH ? CL_BRANCH : CL_NONE;
  endfunction
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core
// with shared-memory handshake, timeout/illegal-opcode halt and a retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             ir_wr,
  output logic             ab_wr,
  output logic             alu_out_wr,
  output logic             reg_wr,
  output logic [1:0]       wb_sel,
  output logic             pc_wr,
  output logic             pc_src,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instret
);
  localparam int WW = $clog2(TIMEOUT);
  ctrl_state_t      r_state;
  op_class_t        r_class;
  logic             r_req;
  logic [WW-1:0]    r_wait;
  logic             r_err_illegal;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_instret;
  op_class_t        w_class;
  logic             w_done;
  logic             w_tmo;
  logic             w_retire;
  assign w_class  = op_class(opcode);
  assign w_done   = r_req && mem_ready;
  assign w_tmo    = r_req && !mem_ready && r_wait == WW'(TIMEOUT - 1);
  assign w_retire = (r_state == S_EXEC && r_class == CL_BRANCH) ||
                    (r_state == S_MEM && r_class == CL_STORE && w_done) ||
                    r_state == S_WB;
  // r_req is cleared by reset, so the first FETCH after reset spends one cycle raising it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_class       <= CL_NONE;
      r_req         <= 1'b0;
      r_wait        <= '0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      r_instret     <= '0;
    end else begin
      r_wait <= '0;
      if (w_retire) r_instret <= r_instret + 1'b1;
      case (r_state)
        S_FETCH, S_MEM: begin
          if (!r_req) r_req <= 1'b1;
          else if (mem_ready) begin
            r_state <= r_state == S_FETCH ? S_DECODE : (r_class == CL_STORE ? S_FETCH : S_WB);
            r_req   <= r_state == S_MEM && r_class == CL_STORE;
          end else if (w_tmo) begin
            r_state       <= S_HALT;
            r_req         <= 1'b0;
            r_err_timeout <= 1'b1;
          end else r_wait <= r_wait + 1'b1;
        end
        S_DECODE: begin
          r_class <= w_class;
          if (w_class == CL_NONE) begin
            r_state       <= S_HALT;
            r_err_illegal <= 1'b1;
          end else r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= (r_class == CL_LOAD || r_class == CL_STORE) ? S_MEM :
                     r_class == CL_BRANCH ? S_FETCH : S_WB;
          r_req   <= r_class != CL_R && r_class != CL_I;
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        default: r_req <= 1'b0;
      endcase
    end
  end
  assign mem_req     = r_req;
  assign addr_sel    = r_state == S_MEM;
  assign mem_wr      = r_state == S_MEM && r_class == CL_STORE;
  assign ir_wr       = r_state == S_FETCH && w_done;
  assign ab_wr       = r_state == S_DECODE;
  assign alu_out_wr  = r_state == S_EXEC;
  assign reg_wr      = r_state == S_WB;
  assign wb_sel      = {1'b0, r_state == S_WB && r_class == CL_LOAD};
  assign pc_wr       = w_retire;
  assign pc_src      = r_state == S_EXEC && r_class == CL_BRANCH && br_taken;
  assign halted      = r_state == S_HALT;
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;
  assign instret     = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven cycle vectors plus timeout and mid-MEM reset sequences.
module tb_multicycle_ctrl;
  localparam logic [6:0] OR = 7'b0110011, OI = 7'b0010011, OL = 7'b0000011;
  localparam logic [6:0] OS = 7'b0100011, OB = 7'b1100011, OX = 7'b1111111;
  localparam logic [13:0] REQ = 14'd1 << 13, WR = 14'd1 << 12, AS = 14'd1 << 11, IR = 14'd1 << 10;
  localparam logic [13:0] AB = 14'd1 << 9, ALU = 14'd1 << 8, RW = 14'd1 << 7, WBM = 14'd1 << 5;
  localparam logic [13:0] PC = 14'd1 << 4, PS = 14'd1 << 3, HLT = 14'd1 << 2, EIL = 14'd1 << 1, ETO = 14'd1;
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        bt;
    logic        rdy;
    logic [13:0] exp;
    int unsigned cnt;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, br_taken = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic mem_req, mem_wr, addr_sel, ir_wr, ab_wr, alu_out_wr, reg_wr, pc_wr, pc_src;
  logic halted, err_illegal, err_timeout;
  logic [1:0] wb_sel;
  logic [31:0] instret;
  int checks = 0, errors = 0;
  vec_t tbl[32];
  always #5 clk = ~clk;
  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_wr(ir_wr), .ab_wr(ab_wr),
    .alu_out_wr(alu_out_wr), .reg_wr(reg_wr), .wb_sel(wb_sel), .pc_wr(pc_wr), .pc_src(pc_src),
    .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout), .instret(instret)
  );
  task automatic step(input logic r, input logic [6:0] op, input logic bt, input logic rdy,
                      input logic [13:0] exp, input int unsigned cnt, input string name);
    logic [13:0] act;
    @(negedge clk);
    rst = r; opcode = op; br_taken = bt; mem_ready = rdy;
    #1;
    act = {mem_req, mem_wr, addr_sel, ir_wr, ab_wr, alu_out_wr, reg_wr, wb_sel, pc_wr, pc_src,
           halted, err_illegal, err_timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", name, act, exp);
    end
    checks++;
    if (instret !== cnt) begin
      errors++;
      $display("FAIL %s instret got %0d want %0d", name, instret, cnt);
    end
  endtask
  initial begin
    tbl[0]  = '{1'b0, OR, 1'b0, 1'b1, 14'd0, 0};
    tbl[1]  = '{1'b0, OR, 1'b0, 1'b1, REQ | IR, 0};
    tbl[2]  = '{1'b0, OR, 1'b0, 1'b1, AB, 0};
    tbl[3]  = '{1'b0, OR, 1'b0, 1'b1, ALU, 0};
    tbl[4]  = '{1'b0, OR, 1'b0, 1'b1, RW | PC, 0};
    tbl[5]  = '{1'b0, OL, 1'b0, 1'b1, REQ | IR, 1};
    tbl[6]  = '{1'b0, OL, 1'b0, 1'b1, AB, 1};
    tbl[7]  = '{1'b0, OL, 1'b0, 1'b0, ALU, 1};
    tbl[8]  = '{1'b0, OL, 1'b0, 1'b0, REQ | AS, 1};
    tbl[9]  = '{1'b0, OL, 1'b0, 1'b0, REQ | AS, 1};
    tbl[10] = '{1'b0, OL, 1'b0, 1'b1, REQ | AS, 1};
    tbl[11] = '{1'b0, OL, 1'b0, 1'b1, RW | WBM | PC, 1};
    tbl[12] = '{1'b0, OB, 1'b1, 1'b1, REQ | IR, 2};
    tbl[13] = '{1'b0, OB, 1'b1, 1'b1, AB, 2};
    tbl[14] = '{1'b0, OB, 1'b1, 1'b1, ALU | PC | PS, 2};
    tbl[15] = '{1'b0, OB, 1'b0, 1'b1, REQ | IR, 3};
    tbl[16] = '{1'b0, OB, 1'b0, 1'b1, AB, 3};
    tbl[17] = '{1'b0, OB, 1'b0, 1'b1, ALU | PC, 3};
    tbl[18] = '{1'b0, OS, 1'b0, 1'b1, REQ | IR, 4};
    tbl[19] = '{1'b0, OS, 1'b0, 1'b1, AB, 4};
    tbl[20] = '{1'b0, OS, 1'b0, 1'b1, ALU, 4};
    tbl[21] = '{1'b0, OS, 1'b0, 1'b1, REQ | WR | AS | PC, 4};
    tbl[22] = '{1'b0, OI, 1'b0, 1'b1, REQ | IR, 5};
    tbl[23] = '{1'b0, OI, 1'b0, 1'b1, AB, 5};
    tbl[24] = '{1'b0, OI, 1'b0, 1'b1, ALU, 5};
    tbl[25] = '{1'b0, OI, 1'b0, 1'b1, RW | PC, 5};
    tbl[26] = '{1'b0, OX, 1'b0, 1'b1, REQ | IR, 6};
    tbl[27] = '{1'b0, OX, 1'b0, 1'b1, AB, 6};
    tbl[28] = '{1'b0, OX, 1'b0, 1'b1, HLT | EIL, 6};
    tbl[29] = '{1'b0, OX, 1'b0, 1'b1, HLT | EIL, 6};
    tbl[30] = '{1'b1, OX, 1'b0, 1'b1, HLT | EIL, 6};
    tbl[31] = '{1'b0, OR, 1'b0, 1'b1, 14'd0, 0};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].bt, tbl[i].rdy, tbl[i].exp, tbl[i].cnt, $sformatf("vec%0d", i));
    for (int i = 0; i < 16; i++) step(1'b0, OR, 1'b0, 1'b0, REQ, 0, $sformatf("tmo_wait%0d", i));
    step(1'b0, OR, 1'b0, 1'b0, HLT | ETO, 0, "tmo_halt");
    step(1'b1, OR, 1'b0, 1'b0, HLT | ETO, 0, "tmo_rst");
    step(1'b0, OR, 1'b0, 1'b0, 14'd0, 0, "tmo2_bubble");
    for (int i = 0; i < 15; i++) step(1'b0, OR, 1'b0, 1'b0, REQ, 0, $sformatf("tmo2_wait%0d", i));
    step(1'b0, OR, 1'b0, 1'b1, REQ | IR, 0, "tmo2_last_ready");
    step(1'b0, OL, 1'b0, 1'b0, AB, 0, "tmo2_decode");
    step(1'b0, OL, 1'b0, 1'b0, ALU, 0, "rmem_exec");
    step(1'b0, OL, 1'b0, 1'b0, REQ | AS, 0, "rmem_mem");
    step(1'b1, OL, 1'b0, 1'b0, REQ | AS, 0, "rmem_rst");
    step(1'b0, OL, 1'b0, 1'b1, 14'd0, 0, "rmem_cleared");
    step(1'b0, OL, 1'b0, 1'b0, REQ, 0, "rmem_fetch");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
